dmem_resp_unit: RTL
===================

DMEM_RESP_UNIT -- requirements
Module: dmem_resp_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the array; power of two, >= 2.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request accept to first resp_vld; range 1..15.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_ctrl  in  dmem_req_ctrl_t (4)  request control: vld, mtype (0 = read, 1 = write), len.
REQ-006 SHALL have port req_addr  in  N_BITS  byte address.
REQ-007 SHALL have port req_wdata  in  N_BITS  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 SHALL have port req_rdy  out  1  unit can accept a request this cycle.
REQ-009 SHALL have port resp_vld  out  1  response valid.
REQ-010 SHALL have port resp_rdata  out  N_BITS  load data, right-aligned, zero-extended.
REQ-011 SHALL have port resp_err  out  1  access rejected.
REQ-012 SHALL have port resp_rdy  in  1  requester accepts the response.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP; req_rdy = (state == IDLE) && !rst.
REQ-014 SHALL accept a request on a rising edge where req_ctrl.vld && req_rdy; signals are sampled only at that edge.
REQ-015 SHALL, on accept, go to RESP if LATENCY == 1, else to WAIT with counter loaded to LATENCY-2.
REQ-016 SHALL, in WAIT, decrement the counter each cycle and go to RESP when it is 0; resp_vld is high exactly LATENCY cycles after the accept edge.
REQ-017 SHALL hold resp_vld, resp_rdata and resp_err stable in RESP until resp_vld && resp_rdy, then go to IDLE; no new accept happens in that same cycle.
REQ-018 SHALL drive resp_vld = 0 outside RESP; resp_rdata and resp_err SHALL read 0 outside RESP.
REQ-019 SHALL decode len as 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-020 SHALL form word index = req_addr[2 +: log2(DEPTH_WORDS)]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-021 SHALL, on an accepted write, commit to the array at the accept edge.
  - byte: lane req_addr[1:0] takes req_wdata[7:0].
  - half: lanes {req_addr[1],0} and {req_addr[1],1} take req_wdata[15:0].
  - word: all lanes.
  - All other lanes are unchanged.
REQ-022 SHALL, on an accepted read, capture the addressed word at the accept edge, shifted right by 8*req_addr[1:0] (byte) or 16*req_addr[1] (half), masked to len width.
REQ-023 SHALL return resp_rdata = 0 for writes.
REQ-024 SHALL make a read of the same address as the immediately preceding write return the written data.

Reset
REQ-025 SHALL, while rst is high at an edge, force state = IDLE, counter = 0, and the captured rdata/err registers = 0, overriding any in-flight request or response, which is discarded.
REQ-026 SHALL NOT reset array contents; after rst deasserts, req_rdy = 1 on the first cycle.

Configuration
REQ-027 SHALL support macro DMEM_ALIGN_CHK_EN.
REQ-028 SHALL, when DMEM_ALIGN_CHK_EN is defined, reject len = 11, a half with addr[0] = 1, or a word with addr[1:0] != 0.
  - No array access is made.
  - The response has normal LATENCY timing, resp_err = 1 and resp_rdata = 0.
REQ-029 SHALL, when DMEM_ALIGN_CHK_EN is undefined:
  - tie resp_err to 0;
  - treat len = 11 as word;
  - ignore misaligned low bits (half uses addr[1] only, word uses no low bits).

Structure
REQ-030 SHALL take dmem_req_ctrl_t, N_BITS from core_types_pkg.
REQ-031 SHALL add these to core_types_pkg:
  - dmem_len_e (DMEM_LEN_B = 2'b00, DMEM_LEN_H = 2'b01, DMEM_LEN_W = 2'b10);
  - dmem_resp_t packed struct {vld, err, rdata[N_BITS-1:0]}.
REQ-032 SHALL place storage in sub-module dmem_sram: single port, byte write enables, DEPTH_WORDS x 32, synchronous write, asynchronous read.

Verification
REQ-033 SHALL cover, with LATENCY = 2: write word 0xDEADBEEF @0x10, then read word @0x10 -> resp_vld 2 cycles after each accept, rdata = 0xDEADBEEF, err = 0.
REQ-034 SHALL cover byte store 0xAA @0x13 over 0x11223344, then read byte @0x13 -> 0x000000AA; read word @0x10 -> 0xAA223344.
REQ-035 SHALL cover backpressure: hold resp_rdy = 0 for 5 cycles -> resp_vld and rdata stable, req_rdy = 0 throughout; req_rdy = 1 the cycle after the resp_rdy handshake.
REQ-036 SHALL cover, with DMEM_ALIGN_CHK_EN: word write @0x12 -> err = 1, rdata = 0, array unchanged; without the macro -> writes @0x10.
REQ-037 SHALL cover rst asserted in WAIT -> next cycle resp_vld = 0, req_rdy = 0; after deassert req_rdy = 1 and no stale response appears.
REQ-038 SHALL cover DEPTH_WORDS = 1024: write @0x1000 -> read @0x0 returns the same data (wrap).

Source files
------------

// File: rtl/core_types_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_types_pkg
// Purpose : Shared core types; data-memory request/response encodings.
// Rev     : 1.0  initial release
// ============================================================================
package core_types_pkg;

    localparam int N_BITS = 32;

    typedef struct packed {
        logic       vld;
        logic       mtype;
        logic [1:0] len;
    } dmem_req_ctrl_t;

    typedef enum logic [1:0] {
        DMEM_LEN_B = 2'b00,
        DMEM_LEN_H = 2'b01,
        DMEM_LEN_W = 2'b10
    } dmem_len_e;

    typedef struct packed {
        logic              vld;
        logic              err;
        logic [N_BITS-1:0] rdata;
    } dmem_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Lane enables; a reserved length behaves as a full word.
    function automatic logic [3:0] dmem_byte_en(input logic [1:0] len, input logic [1:0] lo);
        logic [3:0] be;
        case (len)
            DMEM_LEN_B: be = 4'b0001 << lo;
            DMEM_LEN_H: be = lo[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_sram.sv
`default_nettype none
// ============================================================================
// Module  : dmem_sram
// Purpose : Single-port word array, byte write enables, sync write/async read.
// Rev     : 1.0  initial release
// ============================================================================
module dmem_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/dmem_resp_unit.sv
`default_nettype none
// ============================================================================
// Module  : dmem_resp_unit
// Purpose : Fixed-latency data memory with registered, back-pressurable response.
//           Optional alignment checking via macro DMEM_ALIGN_CHK_EN.
// Rev     : 1.0  initial release
// ============================================================================
module dmem_resp_unit
    import core_types_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  dmem_req_ctrl_t    req_ctrl,
    input  logic [N_BITS-1:0] req_addr,
    input  logic [N_BITS-1:0] req_wdata,
    output logic              req_rdy,
    output logic              resp_vld,
    output logic [N_BITS-1:0] resp_rdata,
    output logic              resp_err,
    input  logic              resp_rdy
);

    localparam int         AW         = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_cnt_load = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    dmem_state_e       r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [N_BITS-1:0] r_rdata, w_rd_word, w_rd_data, w_wdata_lanes;
    logic              r_err, w_err, w_accept, w_we;
    logic [AW-1:0]     w_idx;
    logic [3:0]        w_be;
    dmem_resp_t        w_resp;
    logic              w_unused;

    assign req_rdy  = (r_state == ST_IDLE) && !rst;
    assign w_accept = req_ctrl.vld && req_rdy;
    assign w_idx    = req_addr[2 +: AW];
    assign w_unused = ^req_addr[N_BITS-1:AW+2];

`ifdef DMEM_ALIGN_CHK_EN
    assign w_err = (req_ctrl.len == 2'b11) ||
                   ((req_ctrl.len == DMEM_LEN_H) && req_addr[0]) ||
                   ((req_ctrl.len == DMEM_LEN_W) && (req_addr[1:0] != 2'b00));
`else
    assign w_err = 1'b0;
`endif

    assign w_we = w_accept && req_ctrl.mtype && !w_err;
    assign w_be = dmem_byte_en(req_ctrl.len, req_addr[1:0]);

    always_comb begin
        case (req_ctrl.len)
            DMEM_LEN_B: w_wdata_lanes = {4{req_wdata[7:0]}};
            DMEM_LEN_H: w_wdata_lanes = {2{req_wdata[15:0]}};
            default:    w_wdata_lanes = req_wdata;
        endcase
    end

    dmem_sram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clk    (clk),
        .i_we   (w_we),
        .i_be   (w_be),
        .i_addr (w_idx),
        .i_wdata(w_wdata_lanes),
        .o_rdata(w_rd_word)
    );

    // Load data is right-aligned and zero-extended; writes and errors return 0.
    always_comb begin
        w_rd_data = '0;
        if (!req_ctrl.mtype && !w_err) begin
            case (req_ctrl.len)
                DMEM_LEN_B: w_rd_data = (w_rd_word >> {req_addr[1:0], 3'b000}) & 32'h0000_00FF;
                DMEM_LEN_H: w_rd_data = (w_rd_word >> {req_addr[1], 4'b0000}) & 32'h0000_FFFF;
                default:    w_rd_data = w_rd_word;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_cnt_load;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_rdata <= w_rd_data;
                r_err   <= w_err;
            end
        end
    end

    assign w_resp.vld   = (r_state == ST_RESP);
    assign w_resp.err   = w_resp.vld && r_err;
    assign w_resp.rdata = w_resp.vld ? r_rdata : '0;

    assign resp_vld   = w_resp.vld;
    assign resp_err   = w_resp.err;
    assign resp_rdata = w_resp.rdata;

endmodule
`default_nettype wire
